// File: rtl/collision_detector_if.sv
// Collision detector bus.
// The master drives the scan request, the player position and the platform
// table entry. The slave drives the table read address, the results and the
// status.
//   scan_start           : one-cycle scan request pulse
//   player_x/player_y    : player box top-left corner
//   plat_idx             : platform table read address
//   plat_x/y/w/h         : table entry at plat_idx, valid in the same cycle
//   on_ground/support_y  : ground contact flag and support surface y
//   hit_ceiling/hit_left_wall/hit_right_wall : contact flags
//   busy/scan_done       : scan in progress / one-cycle completion pulse
interface collision_detector_if;
  logic       scan_start;
  logic [9:0] player_x;
  logic [9:0] player_y;
  logic [2:0] plat_idx;
  logic [9:0] plat_x;
  logic [9:0] plat_y;
  logic [9:0] plat_w;
  logic [9:0] plat_h;
  logic       on_ground;
  logic [9:0] support_y;
  logic       hit_ceiling;
  logic       hit_left_wall;
  logic       hit_right_wall;
  logic       busy;
  logic       scan_done;

  modport master (
    output scan_start, player_x, player_y, plat_x, plat_y, plat_w, plat_h,
    input  plat_idx, on_ground, support_y, hit_ceiling, hit_left_wall,
           hit_right_wall, busy, scan_done
  );

  modport slave (
    input  scan_start, player_x, player_y, plat_x, plat_y, plat_w, plat_h,
    output plat_idx, on_ground, support_y, hit_ceiling, hit_left_wall,
           hit_right_wall, busy, scan_done
  );
endinterface

// File: rtl/collision_detector.sv
// Collision detector.
// On scan_start the player position is snapshotted. The platform table is then
// walked one entry per cycle and the ground, ceiling and wall contacts are
// accumulated. The floor at GROUND_Y is merged in, and the results are
// published together with a scan_done pulse.
// Ports:
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : collision_detector_if.slave (request, table read, results, status)
module collision_detector #(
  parameter int NUM_PLAT = 8,
  parameter int PLAYER_W = 16,
  parameter int PLAYER_H = 16,
  parameter int GROUND_Y = 360,
  parameter int LAND_TOL = 12,
  parameter int EDGE_TOL = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  collision_detector_if.slave  bus
);

  localparam logic [10:0] PW11   = 11'(PLAYER_W);
  localparam logic [10:0] PH11   = 11'(PLAYER_H);
  localparam logic [10:0] GY11   = 11'(GROUND_Y);
  localparam logic [10:0] LT11   = 11'(LAND_TOL);
  localparam logic [10:0] ET11   = 11'(EDGE_TOL);
  localparam logic [2:0]  LAST   = 3'(NUM_PLAT - 1);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t      state, state_nxt;
  logic [2:0]  idx;
  logic [9:0]  bx, by;
  logic        ground_acc, ceil_acc, left_acc, right_acc;
  logic [9:0]  support_acc;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (bus.scan_start) state_nxt = SCAN;
      SCAN:   if (idx == LAST)    state_nxt = COMMIT;
      COMMIT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    bus.busy     = (state != IDLE);
    bus.plat_idx = idx;
  end

  // Geometry of the current entry against the snapshot. Everything is
  // widened to 11 bits so that x+w and y+h cannot wrap.
  logic [10:0] bx11, by11, px11, py11;
  logic [10:0] bx_rt, by_bot, px_rt, py_bot;
  logic        entry_valid, hov, vov;
  logic        ground_hit, ceil_hit, left_hit, right_hit;

  always_comb begin
    bx11   = {1'b0, bx};
    by11   = {1'b0, by};
    px11   = {1'b0, bus.plat_x};
    py11   = {1'b0, bus.plat_y};
    bx_rt  = bx11 + PW11;
    by_bot = by11 + PH11;
    px_rt  = px11 + {1'b0, bus.plat_w};
    py_bot = py11 + {1'b0, bus.plat_h};

    entry_valid = (bus.plat_w != '0);
    hov = (bx_rt > px11) && (bx11 < px_rt);
    vov = (by_bot > py11) && (by11 < py_bot);

    ground_hit = entry_valid && hov && (py11 <= by_bot) && (by_bot <= py11 + LT11);
    ceil_hit   = entry_valid && hov && (by11 <= py_bot) && (py_bot <= by11 + ET11);
    left_hit   = entry_valid && vov && (bx11 <= px_rt)  && (px_rt <= bx11 + ET11);
    right_hit  = entry_valid && vov && (px11 <= bx_rt)  && (bx_rt <= px11 + ET11);
  end

  // Floor merge at commit: the floor competes with the table candidates
  // under the same min rule.
  logic       floor_hit, commit_ground;
  logic [9:0] commit_support;

  always_comb begin
    floor_hit     = (by_bot >= GY11);
    commit_ground = ground_acc || floor_hit;
    if (floor_hit && (!ground_acc || (GY11 < {1'b0, support_acc})))
      commit_support = 10'(GROUND_Y);
    else
      commit_support = support_acc;
  end

  // Datapath: snapshot, accumulators and published results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx                <= '0;
      bx                 <= '0;
      by                 <= '0;
      ground_acc         <= 1'b0;
      ceil_acc           <= 1'b0;
      left_acc           <= 1'b0;
      right_acc          <= 1'b0;
      support_acc        <= '1;
      bus.on_ground      <= 1'b1;
      bus.support_y      <= 10'(GROUND_Y);
      bus.hit_ceiling    <= 1'b0;
      bus.hit_left_wall  <= 1'b0;
      bus.hit_right_wall <= 1'b0;
      bus.scan_done      <= 1'b0;
    end else begin
      bus.scan_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.scan_start) begin
            bx          <= bus.player_x;
            by          <= bus.player_y;
            idx         <= '0;
            ground_acc  <= 1'b0;
            ceil_acc    <= 1'b0;
            left_acc    <= 1'b0;
            right_acc   <= 1'b0;
            support_acc <= '1;
          end
        end
        SCAN: begin
          if (ground_hit) begin
            ground_acc <= 1'b1;
            if (bus.plat_y < support_acc) support_acc <= bus.plat_y;
          end
          if (ceil_hit)  ceil_acc  <= 1'b1;
          if (left_hit)  left_acc  <= 1'b1;
          if (right_hit) right_acc <= 1'b1;
          if (idx != LAST) idx <= idx + 3'd1;
        end
        COMMIT: begin
          idx                <= '0;
          bus.on_ground      <= commit_ground;
          // With no ground candidate at all, support_y keeps its last value.
          if (commit_ground) bus.support_y <= commit_support;
          bus.hit_ceiling    <= ceil_acc;
          bus.hit_left_wall  <= left_acc;
          bus.hit_right_wall <= right_acc;
          bus.scan_done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
